// File: rtl/seed_random_3_data_path.sv
// Blackjack card source datapath: free-running 16-bit Fibonacci LFSR whose
// current state is mapped to {2'b00, suit, rank 1..13} and registered on request.

module seed_random_3_data_path_modstage #(
  parameter logic [7:0] K   = 8'd13,
  parameter int         W_O = 8
) (
  input  logic [7:0]     x_i,
  output logic [W_O-1:0] y_o
);
  logic [7:0] y;

  always_comb begin
    y   = (x_i >= K) ? (x_i - K) : x_i;
    y_o = W_O'(y);
  end
endmodule

module seed_random_3_data_path #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk_dp_i,
  input  logic       rst_dp_i,
  input  logic       req_card_state_dp_i,
  output logic [7:0] card_to_send_dp_o
);
  localparam logic [15:0] RST_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          STAGES  = 4;

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  card_q, card_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = {lfsr_q[14:0], fb};
  end

  // x mod 13 for x in 0..255: conditional subtract of 13*16, 13*8, 13*4, 13*2, 13.
  // Each stage leaves the residue below its own constant, so one pass is exact.
  logic [STAGES:0][7:0] rem;
  logic [3:0]           rem_fin;
  logic [3:0]           rank;

  assign rem[0] = lfsr_q[7:0];

  for (genvar g = 0; g < STAGES; g++) begin : g_mod
    localparam logic [7:0] K = 8'd208 >> g;
    seed_random_3_data_path_modstage #(.K(K), .W_O(8)) u_stage (
      .x_i (rem[g]),
      .y_o (rem[g+1])
    );
  end

  seed_random_3_data_path_modstage #(.K(8'd13), .W_O(4)) u_stage_last (
    .x_i (rem[STAGES]),
    .y_o (rem_fin)
  );

  always_comb begin
    rank   = rem_fin + 4'd1;
    card_d = req_card_state_dp_i ? {2'b00, lfsr_q[9:8], rank} : card_q;
  end

  always_ff @(posedge clk_dp_i or negedge rst_dp_i) begin
    if (!rst_dp_i) begin
      lfsr_q <= RST_VAL;
      card_q <= 8'h00;
    end else begin
      lfsr_q <= lfsr_d;
      card_q <= card_d;
    end
  end

  assign card_to_send_dp_o = card_q;
endmodule

// File: tb/tb_seed_random_3_data_path.sv
// Directed bench for the card source datapath: reset, known draws, hold,
// pulse train against a cycle-indexed reference, async reset replay, full period.

module tb_seed_random_3_data_path;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic [7:0] card;

  int n_chk = 0;
  int n_err = 0;

  seed_random_3_data_path #(.SEED(SEED)) dut (
    .clk_dp_i            (clk),
    .rst_dp_i            (rst_n),
    .req_card_state_dp_i (req),
    .card_to_send_dp_o   (card)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: LFSR stepped from the polynomial, card mapping via integer modulo.
  logic [15:0] m_lfsr;
  logic [7:0]  m_card;

  function automatic logic [7:0] card_of(input logic [15:0] l);
    int r;
    r = int'(l[7:0]) % 13 + 1;
    return {2'b00, l[9:8], 4'(r)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_card <= 8'h00;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (req) m_card <= card_of(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check it takes effect at once, release one edge later.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_card", 32'(card), 32'h00);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    @(posedge clk);
    #1;
    chk("rst_hold_card", 32'(card), 32'h00);
    rst_n = 1'b1;
  endtask

  logic [7:0] pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] run_a [8];
  logic [7:0] held;
  int hits, last_hit, zeros;

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    step();
    step();
    chk("por_card", 32'(card), 32'h00);
    chk("por_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_rst", 32'(card), 32'h00);
    end

    // Draws on the first two edges after release.
    do_reset();
    req = 1'b1;
    step();
    chk("draw_ace1", 32'(card), 32'h05);
    step();
    chk("draw_59c3", 32'(card), 32'h11);
    req = 1'b0;

    // Single pulse then a long idle: output holds, LFSR keeps moving.
    req = 1'b1;
    step();
    req = 1'b0;
    chk("pulse_model", 32'(card), 32'(m_card));
    held = card;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold", 32'(card), 32'(held));
    end
    req = 1'b1;
    step();
    req = 1'b0;
    chk("after_idle_model", 32'(card), 32'(m_card));

    // Pulse train with range and format invariants.
    for (int i = 0; i < 30; i++) begin
      req = 1'b1;
      step();
      req = 1'b0;
      chk("train_model", 32'(card), 32'(m_card));
      chk("train_rank_ok", 32'(card[3:0] >= 4'd1 && card[3:0] <= 4'd13), 32'd1);
      chk("train_top0", 32'(card[7:6]), 32'd0);
      step();
      chk("train_hold", 32'(card), 32'(m_card));
    end

    // Replay: same request timing after reset must give the same cards.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = pat[i][0];
      step();
      run_a[i] = card;
      chk("run_a_model", 32'(card), 32'(m_card));
    end
    req = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = pat[i][0];
      step();
    end
    req = 1'b0;
    chk("mid_nonzero", 32'(card != 8'h00), 32'd1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req = pat[i][0];
      step();
      chk("replay", 32'(card), 32'(run_a[i]));
    end
    req = 1'b0;

    // Full period with no requests.
    do_reset();
    hits = 0;
    last_hit = 0;
    zeros = 0;
    for (int i = 1; i <= 65535; i++) begin
      step();
      if (dut.lfsr_q == SEED) begin
        hits++;
        last_hit = i;
      end
      if (dut.lfsr_q == 16'h0000) zeros++;
    end
    chk("period_hits", 32'(hits), 32'd1);
    chk("period_len", 32'(last_hit), 32'd65535);
    chk("never_zero", 32'(zeros), 32'd0);
    chk("period_card_held", 32'(card), 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
